// File: rtl/branch_pred_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pred_pkg
// Purpose  : Shared counter encodings, size defaults and counter-update helper.
// Revision : 1.0
// ============================================================================
package branch_pred_pkg;

  localparam int IDX_W_DEF  = 4;
  localparam int HIST_W_DEF = 4;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] r;
    if (taken) r = (cnt == ST) ? ST : cnt + 2'd1;
    else       r = (cnt == SN) ? SN : cnt - 2'd1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ghr_reg.sv
`default_nettype none
// ============================================================================
// Module   : ghr_reg
// Purpose  : Global branch history shift register; newest outcome in the LSB.
// Revision : 1.0
// ============================================================================
module ghr_reg #(
  parameter int HIST_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [HIST_W-1:0] hist
);

  logic [HIST_W-1:0] hist_q;
  logic [HIST_W-1:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (shift_en) hist_d = (hist_q << 1) | HIST_W'(bit_in);
  end

  always_ff @(posedge clk) begin
    if (reset) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  assign hist = hist_q;

endmodule
`default_nettype wire

// File: rtl/branch_pred_table.sv
`default_nettype none
// ============================================================================
// Module   : branch_pred_table
// Purpose  : 2-bit saturating-counter branch predictor; define
//            BRANCH_PRED_GSHARE_EN for gshare (PC XOR GHR) indexing.
// Revision : 1.0
// ============================================================================
module branch_pred_table
  import branch_pred_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int HIST_W = HIST_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  output logic             prediction,
  output logic             prediction_valid,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int C_ENTRIES = 2 ** IDX_W;

  logic [1:0]       cnt_q [C_ENTRIES];
  logic [1:0]       upd_cnt_d;
  logic             prediction_q;
  logic             prediction_valid_q;
  logic [IDX_W-1:0] pred_idx_q;
  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_idx;
  logic             w_unused_pc;

  assign w_pc_idx    = pred_pc[IDX_W+1:2];
  assign w_unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

`ifdef BRANCH_PRED_GSHARE_EN
  logic [HIST_W-1:0] w_hist;
  logic [IDX_W-1:0]  w_hist_ext;

  ghr_reg #(
    .HIST_W(HIST_W)
  ) u_ghr (
    .clk      (clk),
    .reset    (reset),
    .shift_en (upd_en),
    .bit_in   (upd_taken),
    .hist     (w_hist)
  );

  always_comb begin
    w_hist_ext             = '0;
    w_hist_ext[HIST_W-1:0] = w_hist;
  end

  // History register output is the pre-shift value, so same-cycle updates do not affect the index.
  assign w_idx = w_pc_idx ^ w_hist_ext;
`else
  assign w_idx = w_pc_idx;
`endif

  assign upd_cnt_d = sat_next(cnt_q[upd_idx], upd_taken);

  // Lookup reads cnt_q before this edge's write lands: read-before-write on index collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_ENTRIES; i++) cnt_q[i] <= WN;
      prediction_q       <= 1'b0;
      prediction_valid_q <= 1'b0;
      pred_idx_q         <= '0;
    end else begin
      if (upd_en) cnt_q[upd_idx] <= upd_cnt_d;
      prediction_valid_q <= pred_valid;
      if (pred_valid) begin
        prediction_q <= cnt_q[w_idx][1];
        pred_idx_q   <= w_idx;
      end
    end
  end

  assign prediction       = prediction_q;
  assign prediction_valid = prediction_valid_q;
  assign pred_idx         = pred_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_pred_table
// Purpose  : Directed vector table, hand sequences and random traffic vs model.
// Revision : 1.0
// ============================================================================
module tb_branch_pred_table;

  logic        clk = 1'b0;
  logic        reset, pred_valid, upd_en, upd_taken;
  logic [31:0] pred_pc;
  logic [3:0]  upd_idx;
  logic        prediction, prediction_valid;
  logic [3:0]  pred_idx;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counters as integers 0..3, history as an integer 0..15.
  int m_cnt [16];
  int m_ghr;
  int m_valid, m_pred, m_idx;

  typedef struct {
    logic        rst, pv;
    logic [31:0] pc;
    logic        ue;
    logic [3:0]  ui;
    logic        ut;
    logic        ev, ep;
    logic [3:0]  ei;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  branch_pred_table #(.IDX_W(4), .HIST_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .prediction       (prediction),
    .prediction_valid (prediction_valid),
    .pred_idx         (pred_idx),
    .upd_en           (upd_en),
    .upd_idx          (upd_idx),
    .upd_taken        (upd_taken)
  );

  function automatic vec_t mk(input logic rst, pv, input logic [31:0] pc,
                              input logic ue, input logic [3:0] ui, input logic ut,
                              input logic ev, ep, input logic [3:0] ei);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pc = pc; v.ue = ue; v.ui = ui; v.ut = ut;
    v.ev = ev; v.ep = ep; v.ei = ei;
    return v;
  endfunction

  function automatic int m_index(input logic [31:0] pc);
    int i;
    i = int'(pc / 4) % 16;
`ifdef BRANCH_PRED_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic rst, pv, input logic [31:0] pc,
                            input logic ue, input logic [3:0] ui, input logic ut);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 1;
      m_ghr = 0; m_valid = 0; m_pred = 0; m_idx = 0;
    end else begin
      m_valid = pv;
      if (pv) begin
        m_idx  = m_index(pc);
        m_pred = (m_cnt[m_idx] >= 2) ? 1 : 0;
      end
      if (ue) begin
        if (ut) m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
        else    m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
`ifdef BRANCH_PRED_GSHARE_EN
        m_ghr = (m_ghr * 2 + int'(ut)) % 16;
`endif
      end
    end
  endtask

  // Drive one cycle of inputs, advance model on the edge, then compare.
  task automatic apply(input logic rst, pv, input logic [31:0] pc,
                       input logic ue, input logic [3:0] ui, input logic ut);
    @(negedge clk);
    reset = rst; pred_valid = pv; pred_pc = pc; upd_en = ue; upd_idx = ui; upd_taken = ut;
    @(posedge clk);
    model_edge(rst, pv, pc, ue, ui, ut);
    #1;
    check("model_valid", int'(prediction_valid), m_valid);
    check("model_pred",  int'(prediction),       m_pred);
    check("model_idx",   int'(pred_idx),         m_idx);
  endtask

  initial begin
    reset = 1'b1; pred_valid = 1'b0; pred_pc = '0; upd_en = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 1;
    m_ghr = 0; m_valid = 0; m_pred = 0; m_idx = 0;

    // rst pv pc ue ui ut | valid pred idx   (expectations for bimodal indexing)
    vt.push_back(mk(1, 1, 32'h10, 1, 4, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 0, 4));
    vt.push_back(mk(0, 0, 32'h00, 1, 4, 1, 0, 0, 4));
    vt.push_back(mk(0, 0, 32'h00, 1, 4, 1, 0, 0, 4));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 1, 4));
    for (int k = 0; k < 4; k++) vt.push_back(mk(0, 0, 32'h0, 1, 4, 1, 0, 1, 4));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 1, 4));
    vt.push_back(mk(0, 0, 32'h00, 1, 4, 0, 0, 1, 4));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 1, 4));
    vt.push_back(mk(0, 0, 32'h00, 1, 4, 1, 0, 1, 4));
    for (int k = 0; k < 3; k++) vt.push_back(mk(0, 0, 32'h0, 1, 4, 0, 0, 1, 4));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 0, 4));
    vt.push_back(mk(0, 0, 32'h00, 1, 4, 0, 0, 0, 4));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 0, 4));
    vt.push_back(mk(0, 0, 32'h00, 1, 4, 1, 0, 0, 4));
    vt.push_back(mk(0, 1, 32'h10, 1, 4, 1, 1, 0, 4));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 1, 4));
    vt.push_back(mk(1, 1, 32'h10, 1, 4, 1, 0, 0, 0));
    vt.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 0, 4));

    foreach (vt[k]) begin
      apply(vt[k].rst, vt[k].pv, vt[k].pc, vt[k].ue, vt[k].ui, vt[k].ut);
`ifndef BRANCH_PRED_GSHARE_EN
      check($sformatf("vec%0d_valid", k), int'(prediction_valid), int'(vt[k].ev));
      check($sformatf("vec%0d_pred", k),  int'(prediction),       int'(vt[k].ep));
      check($sformatf("vec%0d_idx", k),   int'(pred_idx),         int'(vt[k].ei));
`endif
    end

    // History: taken, taken, not-taken on an unrelated entry, then look up 0x10.
    apply(1, 0, 32'h0, 0, 0, 0);
    apply(0, 0, 32'h0, 1, 9, 1);
    apply(0, 0, 32'h0, 1, 9, 1);
    apply(0, 0, 32'h0, 1, 9, 0);
    apply(0, 1, 32'h10, 0, 0, 0);
`ifdef BRANCH_PRED_GSHARE_EN
    check("ghr_idx", int'(pred_idx), 2);
`else
    check("bimodal_idx", int'(pred_idx), 4);
`endif
    check("hist_valid", int'(prediction_valid), 1);

    // Reset colliding with update and lookup, then every entry must read weak-NT.
    apply(1, 1, 32'h24, 1, 9, 1);
    check("rst_collide_valid", int'(prediction_valid), 0);
    for (int i = 0; i < 16; i++) begin
      apply(0, 1, 32'(i * 4), 0, 0, 0);
      check($sformatf("rst_entry%0d", i), int'(prediction), 0);
    end

    for (int n = 0; n < 1500; n++) begin
      apply(($urandom_range(0, 99) == 0), 1'($urandom), $urandom,
            1'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
